// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD transmit path: FSM states, A0 select values
// and the command codes used by the LCD state machine.
package lcd_pkg;

  localparam int LCD_DATA_W = 8;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] CMD_START_LINE  = 8'h40;
  localparam logic [7:0] CMD_PAGE_ADDR   = 8'hB0;
  localparam logic [7:0] CMD_COL_HI      = 8'h10;
  localparam logic [7:0] CMD_COL_LO      = 8'h00;
  localparam logic [7:0] CMD_ADC_NORMAL  = 8'hA0;
  localparam logic [7:0] CMD_SOFT_RESET  = 8'hE2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT,
    HOLD
  } lcd_state_t;

endpackage

// File: rtl/lcd_tx_sequencer_fifo.sv
// Synchronous FIFO holding {a0, byte} entries for the LCD transmit sequencer.
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_din,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_tx_sequencer.sv
// Queues LCD command/data bytes and hands them to the SI serializer with
// setup/hold guard windows, a per-byte change_state pulse and gated backlight.
module lcd_tx_sequencer
  import lcd_pkg::*;
#(
  parameter int DATA_W    = LCD_DATA_W,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_a0,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       led_a_req,
  input  logic                       si_ready,
  input  logic                       si_done,
  output logic                       si_start,
  output logic [DATA_W-1:0]          data_stream,
  output logic                       a0,
  output logic                       led_a,
  output logic                       change_state,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int GUARD_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_W     = (GUARD_MAX > 0) ? $clog2(GUARD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  lcd_state_t        r_state;
  lcd_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_si_start;
  logic              w_done_byte;
  logic [DATA_W:0]   w_fifo_dout;
  logic [DATA_W-1:0] r_data;
  logic              r_a0;
  logic              r_led_a;
  logic              r_change_state;
  logic              r_ready_en;

  lcd_cmd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_din   ({in_a0, in_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // r_ready_en keeps in_ready low during reset and for the release cycle.
  assign in_ready     = r_ready_en & ~w_full;
  assign w_push       = in_valid & in_ready;
  assign busy         = (r_state != IDLE);
  assign si_start     = w_si_start;
  assign data_stream  = r_data;
  assign a0           = r_a0;
  assign led_a        = r_led_a;
  assign change_state = r_change_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_si_start  = 1'b0;
    w_done_byte = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (SETUP_CYC == 0) begin
            w_state_nxt = SEND;
          end else begin
            w_state_nxt = SETUP;
            w_cnt_nxt   = SETUP_LOAD;
          end
        end
      end
      SETUP: begin
        if (r_cnt == '0) w_state_nxt = SEND;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      SEND: begin
        if (si_ready) begin
          w_si_start  = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (si_done) begin
          if (HOLD_CYC == 0) begin
            w_state_nxt = IDLE;
            w_done_byte = 1'b1;
          end else begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_done_byte = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_data         <= '0;
      r_a0           <= 1'b0;
      r_led_a        <= 1'b0;
      r_change_state <= 1'b0;
      r_ready_en     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_change_state <= w_done_byte;
      r_ready_en     <= 1'b1;
      if (w_pop) {r_a0, r_data} <= w_fifo_dout;
      if (r_state == IDLE) r_led_a <= led_a_req;
    end
  end

endmodule

// File: tb/tb_lcd_tx_sequencer.sv
// Directed self-checking bench for lcd_tx_sequencer (default guards and zero guards).
module tb_lcd_tx_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_a0;
  logic [7:0] in_data;
  logic       led_a_req;
  logic       si_ready;
  logic       si_done;

  logic       in_ready, si_start, a0, led_a, change_state, busy;
  logic [7:0] data_stream;
  logic [2:0] level;

  logic       in_ready_z, si_start_z, a0_z, led_a_z, change_state_z, busy_z;
  logic [7:0] data_stream_z;
  logic [2:0] level_z;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  lcd_tx_sequencer #(
    .DATA_W    (8),
    .DEPTH     (4),
    .SETUP_CYC (2),
    .HOLD_CYC  (1)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a0        (in_a0),
    .in_data      (in_data),
    .led_a_req    (led_a_req),
    .si_ready     (si_ready),
    .si_done      (si_done),
    .si_start     (si_start),
    .data_stream  (data_stream),
    .a0           (a0),
    .led_a        (led_a),
    .change_state (change_state),
    .busy         (busy),
    .level        (level)
  );

  lcd_tx_sequencer #(
    .DATA_W    (8),
    .DEPTH     (4),
    .SETUP_CYC (0),
    .HOLD_CYC  (0)
  ) u_dut0 (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready_z),
    .in_a0        (in_a0),
    .in_data      (in_data),
    .led_a_req    (led_a_req),
    .si_ready     (si_ready),
    .si_done      (si_done),
    .si_start     (si_start_z),
    .data_stream  (data_stream_z),
    .a0           (a0_z),
    .led_a        (led_a_z),
    .change_state (change_state_z),
    .busy         (busy_z),
    .level        (level_z)
  );

  task automatic drv_idle();
    in_valid  = 1'b0;
    in_a0     = 1'b0;
    in_data   = 8'h00;
    led_a_req = 1'b0;
    si_ready  = 1'b0;
    si_done   = 1'b0;
  endtask

  // Leaves reset low just before the edge that starts the caller's cycle 0.
  task automatic do_reset();
    @(posedge clock); #1;
    drv_idle();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drv_idle();
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if ({in_ready, si_start, a0, led_a, change_state, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {in_ready, si_start, a0, led_a, change_state, busy});
    else n_pass++;
    n_checks++; if (data_stream !== 8'h00) $display("FAIL reset_data: got %h want 00", data_stream); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", in_ready); else n_pass++;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [11:0] exp_start, exp_cs, exp_busy;
    exp_start = 12'h010;
    exp_cs    = 12'h400;
    exp_busy  = 12'h3FC;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      in_valid = (c == 0);
      in_a0    = 1'b0;
      in_data  = 8'hAF;
      si_ready = 1'b1;
      si_done  = (c == 8);
      @(negedge clock);
      n_checks++; if (si_start !== exp_start[c]) $display("FAIL single_start c%0d: got %b want %b", c, si_start, exp_start[c]); else n_pass++;
      n_checks++; if (change_state !== exp_cs[c]) $display("FAIL single_cs c%0d: got %b want %b", c, change_state, exp_cs[c]); else n_pass++;
      n_checks++; if (busy !== exp_busy[c]) $display("FAIL single_busy c%0d: got %b want %b", c, busy, exp_busy[c]); else n_pass++;
      if (c >= 2) begin
        n_checks++; if ({a0, data_stream} !== 9'h0AF) $display("FAIL single_data c%0d: got %b/%h want 0/af", c, a0, data_stream); else n_pass++;
      end
      if (c == 1) begin
        n_checks++; if (level !== 3'd1) $display("FAIL single_level_push: got %0d want 1", level); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (level !== 3'd0) $display("FAIL single_level_pop: got %0d want 0", level); else n_pass++;
      end
    end
  endtask

  task automatic test_fill_stall();
    int exp_lvl[6];
    int dcnt, nbytes, ncs, last_cs;
    exp_lvl = '{0, 1, 1, 2, 3, 4};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_data  = 8'(c + 1);
      in_a0    = 1'((c + 1) & 1);
      si_ready = 1'b0;
      @(negedge clock);
      n_checks++; if (level !== 3'(exp_lvl[c])) $display("FAIL fill_level c%0d: got %0d want %0d", c, level, exp_lvl[c]); else n_pass++;
      n_checks++; if (in_ready !== (c < 5)) $display("FAIL fill_ready c%0d: got %b want %b", c, in_ready, (c < 5)); else n_pass++;
    end
    dcnt = 0; nbytes = 0; ncs = 0; last_cs = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      si_ready = 1'b1;
      si_done  = (dcnt == 1);
      if (dcnt > 0) dcnt--;
      @(negedge clock);
      if (si_start) begin
        n_checks++; if (data_stream !== 8'(nbytes + 1)) $display("FAIL fill_order byte%0d: got %h want %h", nbytes, data_stream, 8'(nbytes + 1)); else n_pass++;
        n_checks++; if (a0 !== 1'((nbytes + 1) & 1)) $display("FAIL fill_a0 byte%0d: got %b want %b", nbytes, a0, 1'((nbytes + 1) & 1)); else n_pass++;
        if (nbytes > 0) begin
          n_checks++; if (c - last_cs !== 3) $display("FAIL back_to_back byte%0d: got %0d want 3", nbytes, c - last_cs); else n_pass++;
        end
        nbytes++;
        dcnt = 2;
      end
      if (change_state) begin
        ncs++;
        last_cs = c;
      end
    end
    n_checks++; if (nbytes !== 5) $display("FAIL fill_starts: got %0d want 5", nbytes); else n_pass++;
    n_checks++; if (ncs !== 5) $display("FAIL fill_cs_count: got %0d want 5", ncs); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL fill_level_end: got %0d want 0", level); else n_pass++;
    n_checks++; if ({busy, in_ready} !== 2'b01) $display("FAIL fill_end_state: got busy/ready %b want 01", {busy, in_ready}); else n_pass++;
  endtask

  task automatic test_early_done();
    logic [13:0] exp_start, exp_cs;
    int ncs;
    exp_start = 14'h0010;
    exp_cs    = 14'h0200;
    ncs = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(posedge clock); #1;
      in_valid = (c == 0);
      in_a0    = 1'b1;
      in_data  = 8'h5A;
      si_ready = 1'b1;
      si_done  = (c == 4) || (c == 7);
      @(negedge clock);
      if (change_state) ncs++;
      n_checks++; if (si_start !== exp_start[c]) $display("FAIL early_start c%0d: got %b want %b", c, si_start, exp_start[c]); else n_pass++;
      n_checks++; if (change_state !== exp_cs[c]) $display("FAIL early_cs c%0d: got %b want %b", c, change_state, exp_cs[c]); else n_pass++;
      if (c == 4) begin
        n_checks++; if ({a0, data_stream} !== 9'h15A) $display("FAIL early_data: got %b/%h want 1/5a", a0, data_stream); else n_pass++;
      end
    end
    n_checks++; if (ncs !== 1) $display("FAIL early_cs_count: got %0d want 1", ncs); else n_pass++;
  endtask

  task automatic test_backlight();
    logic [10:0] exp_led, exp_cs;
    exp_led = 11'h600;
    exp_cs  = 11'h100;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(posedge clock); #1;
      in_valid  = (c == 0);
      in_a0     = 1'b0;
      in_data   = 8'hA0;
      si_ready  = 1'b1;
      led_a_req = (c >= 5);
      si_done   = (c == 6);
      @(negedge clock);
      n_checks++; if (led_a !== exp_led[c]) $display("FAIL led_gate c%0d: got %b want %b", c, led_a, exp_led[c]); else n_pass++;
      n_checks++; if (change_state !== exp_cs[c]) $display("FAIL led_cs c%0d: got %b want %b", c, change_state, exp_cs[c]); else n_pass++;
    end
  endtask

  task automatic test_zero_guards();
    logic [7:0] exp_start, exp_cs, exp_busy;
    exp_start = 8'h04;
    exp_cs    = 8'h20;
    exp_busy  = 8'h1C;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      in_valid = (c == 0);
      in_a0    = 1'b1;
      in_data  = 8'h3C;
      si_ready = 1'b1;
      si_done  = (c == 4);
      @(negedge clock);
      n_checks++; if (si_start_z !== exp_start[c]) $display("FAIL zero_start c%0d: got %b want %b", c, si_start_z, exp_start[c]); else n_pass++;
      n_checks++; if (change_state_z !== exp_cs[c]) $display("FAIL zero_cs c%0d: got %b want %b", c, change_state_z, exp_cs[c]); else n_pass++;
      n_checks++; if (busy_z !== exp_busy[c]) $display("FAIL zero_busy c%0d: got %b want %b", c, busy_z, exp_busy[c]); else n_pass++;
      if (c >= 2) begin
        n_checks++; if ({a0_z, data_stream_z} !== 9'h13C) $display("FAIL zero_data c%0d: got %b/%h want 1/3c", c, a0_z, data_stream_z); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp_start, exp_cs;
    exp_start = 18'h01010;
    exp_cs    = 18'h10000;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(posedge clock); #1;
      in_valid = (c <= 2) || (c == 8);
      in_a0    = (c == 8);
      in_data  = (c == 8) ? 8'hC3 : 8'(8'h10 + c);
      si_ready = 1'b1;
      reset    = (c == 6);
      si_done  = (c == 14);
      @(negedge clock);
      n_checks++; if (si_start !== exp_start[c]) $display("FAIL rmid_start c%0d: got %b want %b", c, si_start, exp_start[c]); else n_pass++;
      n_checks++; if (change_state !== exp_cs[c]) $display("FAIL rmid_cs c%0d: got %b want %b", c, change_state, exp_cs[c]); else n_pass++;
      if (c == 5) begin
        n_checks++; if ({level, busy} !== {3'd2, 1'b1}) $display("FAIL rmid_before: got level %0d busy %b want 2 1", level, busy); else n_pass++;
      end
      if (c == 7) begin
        n_checks++; if (level !== 3'd0) $display("FAIL rmid_level: got %0d want 0", level); else n_pass++;
        n_checks++; if ({in_ready, a0, led_a, busy, data_stream} !== 12'h000) $display("FAIL rmid_outputs: got rdy%b a0%b led%b busy%b data%h want all 0", in_ready, a0, led_a, busy, data_stream); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", in_ready); else n_pass++;
      end
      if (c == 12) begin
        n_checks++; if ({a0, data_stream} !== 9'h1C3) $display("FAIL rmid_data: got %b/%h want 1/c3", a0, data_stream); else n_pass++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_byte();
    test_fill_stall();
    test_early_done();
    test_backlight();
    test_zero_guards();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
